// File: rtl/bp_pkg.sv
// Shared types for the fetch-stage branch predictor:
// counter encoding, BTB entry layout and the saturating update.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    // Widest tag, reached at the smallest legal table (4 entries).
    localparam int TAG_MAX_W = 28;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        ctr_t                 ctr;
    } btb_entry_t;

    function automatic ctr_t sat_update(ctr_t c, logic up);
        if (up)
            return (c == ST) ? ST : c + 2'd1;
        else
            return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch / EX / redirect bundle between the pipeline and the predictor.
// master is the pipeline side, slave is the predictor.
interface branch_predictor_if;

    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        pred_hit;

    logic        ex_branch;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        ex_mispredict;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output if_valid, if_pc,
        output ex_branch, ex_pc, ex_target,
        output ex_pred_taken, ex_mispredict,
        input  pred_taken, pred_target, pred_hit,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  if_valid, if_pc,
        input  ex_branch, ex_pc, ex_target,
        input  ex_pred_taken, ex_mispredict,
        output pred_taken, pred_target, pred_hit,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/bp_sat_counter.sv
// Combinational next-state for a 2-bit saturating counter.
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_t ctr,
    input  logic up,
    output ctr_t ctr_nxt
);

    assign ctr_nxt = sat_update(ctr, up);

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB predictor with 2-bit counters and registered redirect.
// Optional BP_STATS_EN adds branch / mispredict event counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               rst,
`ifdef BP_STATS_EN
    output logic [31:0]        stat_branches,
    output logic [31:0]        stat_mispredicts,
`endif
    branch_predictor_if.slave  bus
);

    btb_entry_t table_q [ENTRIES];

    logic [IDX_W-1:0]     if_idx;
    logic [TAG_MAX_W-1:0] if_tag;
    btb_entry_t           rd;
    logic                 hit;
    logic                 taken;

    assign if_idx = bus.if_pc[IDX_W+1:2];
    assign if_tag = TAG_MAX_W'(bus.if_pc[31:IDX_W+2]);
    assign rd     = table_q[if_idx];
    assign hit    = bus.if_valid & rd.valid & (rd.tag == if_tag);
    assign taken  = hit & rd.ctr[1];

    assign bus.pred_hit    = hit;
    assign bus.pred_taken  = taken;
    assign bus.pred_target = taken ? rd.target : bus.if_pc + 32'd4;

    logic [IDX_W-1:0]     ex_idx;
    logic [TAG_MAX_W-1:0] ex_tag;
    btb_entry_t           ex_e;
    logic                 ex_hit;
    logic                 act;
    logic                 mis;
    ctr_t                 ctr_nxt;

    assign ex_idx = bus.ex_pc[IDX_W+1:2];
    assign ex_tag = TAG_MAX_W'(bus.ex_pc[31:IDX_W+2]);
    assign ex_e   = table_q[ex_idx];
    assign ex_hit = ex_e.valid & (ex_e.tag == ex_tag);
    assign act    = bus.ex_pred_taken ^ bus.ex_mispredict;
    assign mis    = bus.ex_branch & bus.ex_mispredict;

    bp_sat_counter u_ctr (
        .ctr     (ex_e.ctr),
        .up      (act),
        .ctr_nxt (ctr_nxt)
    );

    // Reset has priority, so a write in flight is dropped whole.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
        end else if (bus.ex_branch) begin
            if (ex_hit) begin
                table_q[ex_idx].ctr <= ctr_nxt;
                if (act)
                    table_q[ex_idx].target <= bus.ex_target;
            end else if (act) begin
                table_q[ex_idx] <= '{valid: 1'b1, tag: ex_tag,
                                     target: bus.ex_target, ctr: WT};
            end
        end
    end

    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= mis;
            if (mis)
                redirect_pc_q <= act ? bus.ex_target : bus.ex_pc + 32'd4;
        end
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

`ifdef BP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (bus.ex_branch)
                stat_branches <= stat_branches + 32'd1;
            if (mis)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor (ENTRIES=64).
module tb_branch_predictor;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   nb;
    int   nm;

    branch_predictor_if bus ();

`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_predictor #(.ENTRIES(64)) dut (
        .clk              (clk),
        .rst              (rst),
`ifdef BP_STATS_EN
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
`endif
        .bus              (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic pt, input logic mis);
        @(negedge clk);
        bus.ex_branch     = 1'b1;
        bus.ex_pc         = pc;
        bus.ex_target     = tgt;
        bus.ex_pred_taken = pt;
        bus.ex_mispredict = mis;
        nb++;
        if (mis) nm++;
        @(posedge clk);
        #1;
        bus.ex_branch     = 1'b0;
        bus.ex_mispredict = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        @(negedge clk);
        bus.if_valid = 1'b1;
        bus.if_pc    = pc;
        #1;
    endtask

    task automatic test_reset;
        bus.if_valid = 1'b0; bus.if_pc = '0;
        bus.ex_branch = 1'b0; bus.ex_pc = '0; bus.ex_target = '0;
        bus.ex_pred_taken = 1'b0; bus.ex_mispredict = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        nb = 0; nm = 0;
        #1;
        checks++;
        if (bus.redirect_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_rv got=%0b exp=0", bus.redirect_valid);
        end
        checks++;
        if (bus.redirect_pc !== 32'h0) begin
            failures++;
            $display("FAIL rst_rpc got=%h exp=0", bus.redirect_pc);
        end
        lookup(32'h100);
        checks++;
        if (bus.pred_hit !== 1'b0 || bus.pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL rst_miss hit=%0b tk=%0b exp=0/0",
                     bus.pred_hit, bus.pred_taken);
        end
        checks++;
        if (bus.pred_target !== 32'h104) begin
            failures++;
            $display("FAIL rst_tgt got=%h exp=104", bus.pred_target);
        end
`ifdef BP_STATS_EN
        checks++;
        if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            failures++;
            $display("FAIL rst_stats got=%0d/%0d exp=0/0",
                     stat_branches, stat_mispredicts);
        end
`endif
    endtask

    task automatic test_allocate;
        @(negedge clk);
        bus.if_valid = 1'b1; bus.if_pc = 32'h100;
        bus.ex_branch = 1'b1; bus.ex_pc = 32'h100; bus.ex_target = 32'h40;
        bus.ex_pred_taken = 1'b0; bus.ex_mispredict = 1'b1;
        nb++; nm++;
        #1;
        checks++;
        if (bus.pred_hit !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle_old hit=%0b exp=0", bus.pred_hit);
        end
        @(posedge clk);
        #1;
        bus.ex_branch = 1'b0; bus.ex_mispredict = 1'b0;
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h40) begin
            failures++;
            $display("FAIL alloc_redir v=%0b pc=%h exp=1/40",
                     bus.redirect_valid, bus.redirect_pc);
        end
        lookup(32'h100);
        checks++;
        if (bus.pred_hit !== 1'b1 || bus.pred_taken !== 1'b1 ||
            bus.pred_target !== 32'h40) begin
            failures++;
            $display("FAIL alloc_pred hit=%0b tk=%0b tgt=%h exp=1/1/40",
                     bus.pred_hit, bus.pred_taken, bus.pred_target);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h40) begin
            failures++;
            $display("FAIL redir_pulse v=%0b pc=%h exp=0/40",
                     bus.redirect_valid, bus.redirect_pc);
        end
    endtask

    task automatic test_counter_walk;
        for (int i = 0; i < 4; i++) begin
            resolve(32'h100, 32'h40, 1'b0, 1'b0);
            lookup(32'h100);
            checks++;
            if (bus.pred_hit !== 1'b1 || bus.pred_taken !== 1'b0 ||
                bus.pred_target !== 32'h104) begin
                failures++;
                $display("FAIL walk_nt%0d hit=%0b tk=%0b tgt=%h exp=1/0/104",
                         i, bus.pred_hit, bus.pred_taken, bus.pred_target);
            end
        end
        resolve(32'h100, 32'h80, 1'b1, 1'b0);
        lookup(32'h100);
        checks++;
        if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h104) begin
            failures++;
            $display("FAIL walk_sat00 tk=%0b tgt=%h exp=0/104",
                     bus.pred_taken, bus.pred_target);
        end
        resolve(32'h100, 32'h80, 1'b1, 1'b0);
        lookup(32'h100);
        checks++;
        if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h80) begin
            failures++;
            $display("FAIL walk_up tk=%0b tgt=%h exp=1/80",
                     bus.pred_taken, bus.pred_target);
        end
    endtask

    task automatic test_nt_mispredict;
        resolve(32'h100, 32'h80, 1'b1, 1'b0);
        resolve(32'h100, 32'h80, 1'b1, 1'b1);
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h104) begin
            failures++;
            $display("FAIL nt_redir v=%0b pc=%h exp=1/104",
                     bus.redirect_valid, bus.redirect_pc);
        end
        lookup(32'h100);
        checks++;
        if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h80) begin
            failures++;
            $display("FAIL nt_ctr10 tk=%0b tgt=%h exp=1/80",
                     bus.pred_taken, bus.pred_target);
        end
        resolve(32'h100, 32'h80, 1'b0, 1'b0);
        lookup(32'h100);
        checks++;
        if (bus.pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL nt_ctr01 tk=%0b exp=0", bus.pred_taken);
        end
`ifdef BP_STATS_EN
        checks++;
        if (stat_branches !== 32'(nb) || stat_mispredicts !== 32'(nm)) begin
            failures++;
            $display("FAIL nt_stats got=%0d/%0d exp=%0d/%0d",
                     stat_branches, stat_mispredicts, nb, nm);
        end
`endif
    endtask

    task automatic test_alias;
        resolve(32'h200, 32'h300, 1'b0, 1'b1);
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h300) begin
            failures++;
            $display("FAIL alias_redir v=%0b pc=%h exp=1/300",
                     bus.redirect_valid, bus.redirect_pc);
        end
        lookup(32'h100);
        checks++;
        if (bus.pred_hit !== 1'b0 || bus.pred_target !== 32'h104) begin
            failures++;
            $display("FAIL alias_old hit=%0b tgt=%h exp=0/104",
                     bus.pred_hit, bus.pred_target);
        end
        lookup(32'h200);
        checks++;
        if (bus.pred_hit !== 1'b1 || bus.pred_taken !== 1'b1 ||
            bus.pred_target !== 32'h300) begin
            failures++;
            $display("FAIL alias_new hit=%0b tk=%0b tgt=%h exp=1/1/300",
                     bus.pred_hit, bus.pred_taken, bus.pred_target);
        end
        resolve(32'h400, 32'h500, 1'b0, 1'b0);
        lookup(32'h400);
        checks++;
        if (bus.pred_hit !== 1'b0) begin
            failures++;
            $display("FAIL nt_miss_noalloc hit=%0b exp=0", bus.pred_hit);
        end
        lookup(32'h200);
        checks++;
        if (bus.pred_hit !== 1'b1) begin
            failures++;
            $display("FAIL nt_miss_keep hit=%0b exp=1", bus.pred_hit);
        end
    endtask

    task automatic test_spurious;
        @(negedge clk);
        bus.ex_branch = 1'b0; bus.ex_mispredict = 1'b1;
        bus.ex_pc = 32'h200; bus.ex_target = 32'h990;
        bus.ex_pred_taken = 1'b0;
        @(posedge clk);
        #1;
        bus.ex_mispredict = 1'b0;
        checks++;
        if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h300) begin
            failures++;
            $display("FAIL spur_redir v=%0b pc=%h exp=0/300",
                     bus.redirect_valid, bus.redirect_pc);
        end
        lookup(32'h200);
        checks++;
        if (bus.pred_hit !== 1'b1 || bus.pred_target !== 32'h300) begin
            failures++;
            $display("FAIL spur_table hit=%0b tgt=%h exp=1/300",
                     bus.pred_hit, bus.pred_target);
        end
`ifdef BP_STATS_EN
        checks++;
        if (stat_branches !== 32'(nb) || stat_mispredicts !== 32'(nm)) begin
            failures++;
            $display("FAIL spur_stats got=%0d/%0d exp=%0d/%0d",
                     stat_branches, stat_mispredicts, nb, nm);
        end
`endif
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus.ex_branch = 1'b1; bus.ex_pc = 32'h700; bus.ex_target = 32'h800;
        bus.ex_pred_taken = 1'b0; bus.ex_mispredict = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h800) begin
            failures++;
            $display("FAIL b2b_first v=%0b pc=%h exp=1/800",
                     bus.redirect_valid, bus.redirect_pc);
        end
        bus.ex_pc = 32'h900; bus.ex_target = 32'haaa0;
        bus.ex_pred_taken = 1'b1;
        @(posedge clk);
        #1;
        bus.ex_branch = 1'b0; bus.ex_mispredict = 1'b0;
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h904) begin
            failures++;
            $display("FAIL b2b_second v=%0b pc=%h exp=1/904",
                     bus.redirect_valid, bus.redirect_pc);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h904) begin
            failures++;
            $display("FAIL b2b_end v=%0b pc=%h exp=0/904",
                     bus.redirect_valid, bus.redirect_pc);
        end
    endtask

    task automatic test_mid_write_reset;
        @(negedge clk);
        bus.ex_branch = 1'b1; bus.ex_pc = 32'h500; bus.ex_target = 32'h600;
        bus.ex_pred_taken = 1'b0; bus.ex_mispredict = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.ex_branch = 1'b0; bus.ex_mispredict = 1'b0;
        #1;
        checks++;
        if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h0) begin
            failures++;
            $display("FAIL mid_rst_redir v=%0b pc=%h exp=0/0",
                     bus.redirect_valid, bus.redirect_pc);
        end
        lookup(32'h500);
        checks++;
        if (bus.pred_hit !== 1'b0 || bus.pred_target !== 32'h504) begin
            failures++;
            $display("FAIL mid_rst_entry hit=%0b tgt=%h exp=0/504",
                     bus.pred_hit, bus.pred_target);
        end
        lookup(32'h700);
        checks++;
        if (bus.pred_hit !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_clear hit=%0b exp=0", bus.pred_hit);
        end
`ifdef BP_STATS_EN
        checks++;
        if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            failures++;
            $display("FAIL mid_rst_stats got=%0d/%0d exp=0/0",
                     stat_branches, stat_mispredicts);
        end
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nb       = 0;
        nm       = 0;
        test_reset();
        test_allocate();
        test_counter_walk();
        test_nt_mispredict();
        test_alias();
        test_spurious();
        test_back_to_back();
        test_mid_write_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
